// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter driving the select lines of an external 4:1 mux
module mux_rr_arbiter #(
  parameter int unsigned BURST = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] ack,
  output logic [3:0] gnt,
  output logic       sel0,
  output logic       sel1,
  output logic       out_valid,
  input  logic       out_ready
);

  typedef enum logic {IDLE, GRANT} state_e;

  localparam logic [3:0] LAST_BEAT = 4'(BURST - 1);

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] gnt_q, gnt_d;
  logic [3:0] beat_cnt_q, beat_cnt_d;
  logic [1:0] pick_idx;
  logic [1:0] cand;
  logic       pick_found;
  logic       xfer;

  // Search starts one past the last granted index so every requester gets a turn.
  always_comb begin
    pick_idx   = ptr_q;
    pick_found = 1'b0;
    cand       = ptr_q;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!pick_found && req[cand]) begin
        pick_idx   = cand;
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    beat_cnt_d = beat_cnt_q;
    ack        = 4'b0000;
    out_valid  = 1'b0;
    xfer       = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          idx_d      = pick_idx;
          gnt_d      = 4'b0001 << pick_idx;
          beat_cnt_d = 4'd0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        out_valid = req[idx_q];
        xfer      = out_valid & out_ready;
        if (xfer) begin
          ack        = 4'b0001 << idx_q;
          beat_cnt_d = beat_cnt_q + 4'd1;
        end
        // A dropped request releases even under backpressure, so a misbehaving requester cannot lock the mux.
        if ((xfer && beat_cnt_q == LAST_BEAT) || !req[idx_q]) begin
          ptr_d      = idx_q;
          gnt_d      = 4'b0000;
          beat_cnt_d = 4'd0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= 2'd0;
      ptr_q      <= 2'd3;
      gnt_q      <= 4'b0000;
      beat_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign gnt  = gnt_q;
  assign sel0 = idx_q[0];
  assign sel1 = idx_q[1];

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares the team's 4:1 N-bit multibit mux between four requesters.
- Drives the mux selects (sel0/sel1) from a registered grant.
- Presents the selected requester's data to one downstream consumer over a valid/ready handshake.
- Caps consecutive beats per grant at BURST.
- Datapath stays in the external mux; this block is control only.

Parameters:
- BURST, 4, max beats transferred per grant before forced re-arbitration (legal range 1..15).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  4  request per requester; bit i = mux input a/b/c/d for i=0/1/2/3
- ack  output  4  one-hot, combinational; ack[i]=1 in the cycle requester i's beat is consumed
- gnt  output  4  one-hot registered grant; 0 when idle
- sel0  output  1  mux select LSB (= grant index bit 0)
- sel1  output  1  mux select MSB (= grant index bit 1)
- out_valid  output  1  mux output o holds a valid beat
- out_ready  input  1  consumer accepts the beat

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE, gnt=0, grant index=0, sel1/sel0=0/0, out_valid=0, ack=0, beat_cnt=0.
  - RR pointer=3, so requester 0 has first priority.
- Index mapping: 0→a (sel1=0, sel0=0), 1→b (0,1), 2→c (1,0), 3→d (1,1).
- sel0/sel1 are driven from the registered grant index and are held at the last grant while IDLE.
- State IDLE:
  - out_valid=0, ack=0.
  - If req!=0: grant = first set bit searching ptr+1, ptr+2, ptr+3, ptr (mod 4). Register index and gnt, clear beat_cnt, go GRANT.
  - If req==0: stay IDLE.
- State GRANT (g = grant index):
  - out_valid = req[g] (combinational).
  - Transfer = out_valid & out_ready. In a transfer cycle ack[g]=1, all other ack bits 0; beat_cnt increments.
  - Release when either condition holds:
    - a transfer occurs with beat_cnt==BURST-1;
    - req[g]==0 (no transfer possible that cycle).
  - On release: ptr=g, gnt=0, go IDLE. Otherwise stay in GRANT with grant unchanged.
- Latency:
  - One cycle from req assertion in IDLE to gnt/sel valid; out_valid follows in the same cycle as gnt.
  - Every release costs exactly one IDLE bubble cycle.
- Requester rule: hold req and data stable until ack; dropping req while out_valid=1 and out_ready=0 is a protocol violation. The block still releases cleanly on it.
- Backpressure: with out_ready=0, grant, sel, beat_cnt and out_valid are all held indefinitely.
- BURST=1: release after every beat; requesters strictly alternate under full load.
- Simultaneous events: new requests arriving during GRANT never preempt the current grant. They are evaluated only in IDLE.
- beat_cnt is 4 bits and never exceeds BURST-1.
- Reset mid-transfer: all outputs return to reset values immediately (async); any in-flight beat is not acked.

Test Plan:
- Reset, then req=4'b0001, out_ready=1, held:
  - after 1 cycle: gnt=0001, sel1/sel0=0/0, out_valid=1;
  - ack[0] pulses 4 cycles;
  - release, 1 IDLE bubble, grant to 0 again.
- req=4'b1111, out_ready=1, BURST=4:
  - grant order 0,1,2,3,0;
  - each grant gets 4 acks then 1 bubble;
  - sel pairs 00, 01, 10, 11.
- Grant to 2, out_ready=0 for 5 cycles:
  - out_valid=1, sel=10, ack=0 held;
  - out_ready=1 resumes beat counting from the held value.
- Grant to 1 after 2 beats, req[1] drops:
  - next cycle IDLE;
  - with req=4'b1001, next grant is 3 (ptr=1).
- BURST=1, req=4'b0101:
  - grants alternate 0,2,0,2;
  - one ack per grant, separated by one bubble.
- rst_n low during GRANT with out_valid=1:
  - gnt, ack, out_valid, sel drop to 0 asynchronously;
  - after release, first grant goes to the lowest requesting index.
